// File: rtl/period_meter_pkg.sv
// period_meter_pkg: shared state encoding and default constants for period_meter
package period_meter_pkg;
  typedef enum logic [1:0] {IDLE, MEASURE, LOCKED} state_e;
  localparam int CNT_W_DEF    = 16;
  localparam int EXPECTED_DEF = 80;
  localparam int TOL_DEF      = 2;
  localparam int LOCK_N_DEF   = 4;
endpackage

// File: rtl/sync_edge.sv
// sync_edge: 2-flop synchronizer plus armed rising-edge detector, pulse 3 clk edges after first high sample
module sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic sig_i,
  output logic pulse_o
);
  logic [1:0] sync_q, dly_q, vld_q;
  logic       armed_q, pulse_q;
  // synchronize, delay, and arm only after a genuine low has been seen since reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= '0;
      dly_q   <= '0;
      vld_q   <= '0;
      armed_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], sig_i};
      dly_q   <= {dly_q[0], sync_q[1]};
      vld_q   <= {vld_q[0], 1'b1};
      armed_q <= armed_q | (vld_q[1] & ~sync_q[1]);
      pulse_q <= armed_q & dly_q[0] & ~dly_q[1];
    end
  end
  assign pulse_o = pulse_q;
endmodule

// File: rtl/period_meter.sv
// period_meter: measures sig_in period in clk cycles and locks on EXPECTED+-TOL; PERIOD_METER_TIMEOUT_EN adds a stall timeout
module period_meter
  import period_meter_pkg::*;
#(
  parameter int CNT_W    = CNT_W_DEF,
  parameter int EXPECTED = EXPECTED_DEF,
  parameter int TOL      = TOL_DEF,
  parameter int LOCK_N   = LOCK_N_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  output logic             edge_pulse,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             locked,
  output logic             err
);
  localparam int MW = $clog2(LOCK_N + 1);
  localparam logic [CNT_W:0] EXP_W = (CNT_W+1)'(EXPECTED);
  localparam logic [CNT_W:0] TOL_W = (CNT_W+1)'(TOL);
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, period_q, period_d;
  logic [MW-1:0]    mcnt_q, mcnt_d;
  logic [CNT_W:0]   p_w, dev;
  logic             sat, good, tmo;
  sync_edge u_sync (
    .clk     (clk),
    .rst     (rst),
    .sig_i   (sig_in),
    .pulse_o (edge_pulse)
  );
  assign sat          = &cnt_q;
  assign p_w          = {1'b0, cnt_q};
  assign dev          = p_w > EXP_W ? p_w - EXP_W : EXP_W - p_w;
  assign good         = dev <= TOL_W && !sat;
  assign period_valid = edge_pulse && state_q != IDLE;
  assign cnt_d        = edge_pulse ? CNT_W'(1) : sat ? cnt_q : cnt_q + 1'b1;
  assign period_d     = period_valid ? cnt_q : period_q;
  assign period       = period_d;
  assign locked       = state_q == LOCKED;
`ifdef PERIOD_METER_TIMEOUT_EN
  localparam logic [CNT_W:0] TMO_W = (CNT_W+1)'(2 * EXPECTED);
  assign tmo = state_q != IDLE && p_w > TMO_W;
`else
  assign tmo = 1'b0;
`endif
  // lock FSM: count consecutive good periods, drop to MEASURE on a bad one, err on loss/overflow/timeout
  always_comb begin
    state_d = state_q;
    mcnt_d  = mcnt_q;
    err     = 1'b0;
    if (tmo) begin
      state_d = IDLE;
      mcnt_d  = '0;
      err     = 1'b1;
    end else begin
      case (state_q)
        IDLE:    state_d = edge_pulse ? MEASURE : IDLE;
        MEASURE: begin
          if (period_valid) begin
            mcnt_d = !good ? '0 : mcnt_q == MW'(LOCK_N) ? mcnt_q : mcnt_q + 1'b1;
            err    = sat;
          end else if (mcnt_q == MW'(LOCK_N)) begin
            state_d = LOCKED;
          end
        end
        LOCKED: begin
          if (period_valid && !good) begin
            state_d = MEASURE;
            mcnt_d  = '0;
            err     = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end
  // state, counter, match count and last period registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      mcnt_q   <= '0;
      period_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcnt_q   <= mcnt_d;
      period_q <= period_d;
    end
  end
endmodule

// File: tb/tb_period_meter.sv
// tb_period_meter: directed self-checking bench for period_meter (default and CNT_W=8 instances)
module tb_period_meter;
  logic        clk = 1'b0, rst = 1'b1, sig_a = 1'b0, sig_b = 1'b0;
  logic        edge_a, valid_a, locked_a, err_a;
  logic        edge_b, valid_b, locked_b, err_b;
  logic [15:0] period_a;
  logic [7:0]  period_b;
  int n_chk = 0, n_pass = 0, cyc = 0;
  int edge_n_a = 0, valid_n_a = 0, err_n_a = 0, per_a = 0, edge_cyc = 0, err_cyc = 0;
  int valid_n_b = 0, err_n_b = 0, per_b = 0;
  int lat, snap_e, snap_v, snap_err;
  always #5 clk = ~clk;
  period_meter u_a (
    .clk (clk), .rst (rst), .sig_in (sig_a), .edge_pulse (edge_a),
    .period (period_a), .period_valid (valid_a), .locked (locked_a), .err (err_a)
  );
  period_meter #(.CNT_W(8)) u_b (
    .clk (clk), .rst (rst), .sig_in (sig_b), .edge_pulse (edge_b),
    .period (period_b), .period_valid (valid_b), .locked (locked_b), .err (err_b)
  );
  always @(negedge clk) begin
    cyc++;
    if (edge_a) begin edge_n_a++; edge_cyc = cyc; end
    if (valid_a) begin valid_n_a++; per_a = int'(period_a); end
    if (err_a) begin err_n_a++; err_cyc = cyc; end
    if (valid_b) begin valid_n_b++; per_b = int'(period_b); end
    if (err_b) err_n_b++;
  end
  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask
  task automatic gen(input bit b, input int p);
    if (b) sig_b = 1'b1; else sig_a = 1'b1;
    repeat (p / 2) @(posedge clk);
    #1;
    if (b) sig_b = 1'b0; else sig_a = 1'b0;
    repeat (p - p / 2) @(posedge clk);
    #1;
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_period", int'(period_a), 0);
    check("rst_locked", int'(locked_a), 0);
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    sig_a = 1'b1;
    lat = -1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      if (edge_a && lat < 0) lat = k;
    end
    check("edge_latency", lat, 3);
    check("first_edge_no_valid", valid_n_a, 0);
    repeat (30) @(posedge clk);
    #1;
    sig_a = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) gen(1'b0, 80);
    check("valid_after_3", valid_n_a, 3);
    check("unlocked_after_3", int'(locked_a), 0);
    gen(1'b0, 80);
    check("locked_after_4", int'(locked_a), 1);
    check("steady_period", per_a, 80);
    check("steady_no_err", err_n_a, 0);
    gen(1'b0, 78);
    gen(1'b0, 82);
    check("period_78", per_a, 78);
    check("lock_at_78", int'(locked_a), 1);
    gen(1'b0, 83);
    check("period_82", per_a, 82);
    check("lock_at_82", int'(locked_a), 1);
    check("no_err_78_82", err_n_a, 0);
    gen(1'b0, 80);
    check("period_83", per_a, 83);
    check("err_at_83", err_n_a, 1);
    check("unlock_at_83", int'(locked_a), 0);
    for (int i = 0; i < 3; i++) gen(1'b0, 80);
    check("unlocked_3_relock", int'(locked_a), 0);
    gen(1'b0, 80);
    check("relocked", int'(locked_a), 1);
    check("err_once", err_n_a, 1);
    sig_a = 1'b1;
    repeat (44) @(posedge clk);
    #1;
    check("locked_before_rst", int'(locked_a), 1);
    rst = 1'b1;
    #1;
    check("rst_mid_edge", int'(edge_a), 0);
    check("rst_mid_valid", int'(valid_a), 0);
    check("rst_mid_locked", int'(locked_a), 0);
    check("rst_mid_err", int'(err_a), 0);
    check("rst_mid_period", int'(period_a), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    snap_e = edge_n_a;
    snap_v = valid_n_a;
    repeat (20) @(posedge clk);
    #1;
    check("high_after_rst_no_edge", edge_n_a, snap_e);
    sig_a = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    gen(1'b0, 80);
    check("edge_after_rst", edge_n_a, snap_e + 1);
    check("no_valid_after_rst", valid_n_a, snap_v);
    for (int i = 0; i < 4; i++) gen(1'b0, 80);
    check("relock_after_rst", int'(locked_a), 1);
    snap_err = err_n_a;
    repeat (300) @(posedge clk);
    #1;
`ifdef PERIOD_METER_TIMEOUT_EN
    check("timeout_err", err_n_a, snap_err + 1);
    check("timeout_count", err_cyc - edge_cyc, 161);
    check("timeout_unlock", int'(locked_a), 0);
`else
    check("stall_no_err", err_n_a, snap_err);
    check("stall_locked", int'(locked_a), 1);
`endif
    for (int i = 0; i < 4; i++) gen(1'b1, 300);
`ifdef PERIOD_METER_TIMEOUT_EN
    check("ovf_valid", valid_n_b, 0);
    check("ovf_err", err_n_b, 4);
`else
    check("ovf_valid", valid_n_b, 3);
    check("ovf_err", err_n_b, 3);
    check("ovf_period", per_b, 255);
`endif
    check("ovf_unlocked", int'(locked_b), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/period_meter.md
PERIOD_METER -- requirements
Module: period_meter

Interface
REQ-001 Parameter CNT_W, default 16, is the width of the period counter and of the period output.
REQ-002 Parameter EXPECTED, default 80, is the nominal sig_in period in clk cycles.
REQ-003 Parameter TOL, default 2, is the allowed absolute deviation, in cycles, from EXPECTED.
REQ-004 Parameter LOCK_N, default 4, is the number of consecutive in-tolerance periods required for lock.
REQ-005 Port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-006 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 Port sig_in, input, 1 bit: divided clock under test, asynchronous to clk.
REQ-008 Port edge_pulse, output, 1 bit: one-cycle strobe for each detected sig_in rising edge.
REQ-009 Port period, output, CNT_W bits: last measured period in clk cycles.
REQ-010 Port period_valid, output, 1 bit: one-cycle strobe when period updates.
REQ-011 Port locked, output, 1 bit: high while in state LOCKED.
REQ-012 Port err, output, 1 bit: one-cycle strobe on loss of lock, overflow or timeout.

Function
REQ-013 sig_in SHALL pass through a 2-flop synchronizer; rising-edge detection on the synchronized value SHALL assert edge_pulse exactly 3 clk cycles after the first clk edge that samples sig_in high.
REQ-014 The counter SHALL load 1 on edge_pulse and otherwise increment by 1 each cycle, so that the period equals the clk cycles between consecutive edge_pulse strobes.
REQ-015 On saturation at all-ones, the counter SHALL hold its value; the next edge SHALL report period = all-ones and strobe err.
REQ-016 States: IDLE (reset; waits for the first edge), MEASURE (counting, not locked), LOCKED.
REQ-017 IDLE -> MEASURE on edge_pulse; no period_valid on this first edge.
REQ-018 In MEASURE and LOCKED, each edge_pulse SHALL update period and strobe period_valid in the same cycle.
REQ-019 An in-tolerance period is one with |period-EXPECTED| <= TOL, computed without wrap at CNT_W+1 bits.
REQ-020 In MEASURE, an in-tolerance period SHALL increment the match count and an out-of-tolerance period SHALL clear it.
REQ-021 MEASURE -> LOCKED in the cycle after the match count reaches LOCK_N.
REQ-022 In LOCKED, an out-of-tolerance period SHALL strobe err, clear the match count, and return the FSM to MEASURE.
REQ-023 In MEASURE, an out-of-tolerance period SHALL NOT strobe err, except on overflow.
REQ-024 The edge/period datapath SHALL keep running while an err strobe is issued.

Reset
REQ-025 Asserting rst at any time SHALL immediately force the following values: state IDLE; synchronizer 0; counter 0; match count 0; period 0; and edge_pulse, period_valid, locked and err all 0.
REQ-026 After rst deasserts, a sig_in that is already high SHALL NOT produce an edge_pulse until it first goes low and then rises.

Configuration
REQ-027 With macro PERIOD_METER_TIMEOUT_EN defined:
- If the counter exceeds 2*EXPECTED in MEASURE or LOCKED, the block SHALL strobe err once and return to IDLE.
- The match count SHALL clear on this timeout.
REQ-028 Without PERIOD_METER_TIMEOUT_EN, the block SHALL have no timeout: a stalled sig_in SHALL leave the state unchanged and the counter saturated.

Structure
REQ-029 A shared package period_meter_pkg SHALL hold the state enum (IDLE, MEASURE, LOCKED) and the default constants for CNT_W, EXPECTED, TOL and LOCK_N.
REQ-030 One sub-module, sync_edge (2-flop synchronizer plus rising-edge detector), SHALL be instantiated once.

Verification
REQ-031 Steady clock:
- Stimulus: sig_in with an exact period of 80 clk cycles.
- Response: period_valid every 80 cycles with period=80; locked rises after the 4th valid period; err never strobes.
REQ-032 Tolerance edges:
- Periods of 78 and 82 SHALL keep lock.
- A single period of 83 while LOCKED SHALL strobe err once, drop locked, and re-lock after 4 further periods of 80.
REQ-033 Reset mid-operation:
- Stimulus: rst pulsed while LOCKED with the counter at 40.
- Response: all outputs 0 and state IDLE in the same cycle; the first edge afterwards gives no period_valid.
REQ-034 Overflow: with CNT_W=8 and a sig_in period of 300, the block SHALL report period=255 and strobe err on each edge.
REQ-035 Timeout, with PERIOD_METER_TIMEOUT_EN defined:
- Stimulus: sig_in stalled low while LOCKED.
- Response: err strobes at counter 161, then locked=0 and state IDLE.
- Without the macro: no err, and locked stays 1.
